inst_buffer: RTL and testbench

Decoupling FIFO between the instruction-fetch stage and the decode stage. It captures each fetched (pc, inst) pair with a valid/ready handshake and presents entries to decode in order. It absorbs decode stalls without stalling fetch until the buffer is full. A flush discards all held instructions on a branch redirect.

---
 rtl/inst_buffer_pkg.sv | 14 +
 rtl/inst_buffer_fifo_ctrl.sv | 45 ++++
 rtl/inst_buffer.sv | 66 ++++++
 tb/tb_inst_buffer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_buffer_pkg.sv
// Shared constants for the fetch/decode instruction buffer.
// Bus widths, NOP/reset word and reset polarity used across the front end.
package inst_buffer_pkg;

  localparam int          InstBus     = 32;
  localparam int          InstAddrBus = 32;
  localparam logic [31:0] ZeroWord    = 32'h0;
  localparam logic        RstEnable   = 1'b1;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/inst_buffer_fifo_ctrl.sv
// Pointer/occupancy control for a power-of-two FIFO.
// Pointers carry one extra wrap bit to tell full from empty.
module fifo_ctrl
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH)-1:0] wr_addr,
  output logic [$clog2(DEPTH)-1:0] rd_addr
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign wr_addr = wr_ptr[AW-1:0];
  assign rd_addr = rd_ptr[AW-1:0];

endmodule

// File: rtl/inst_buffer.sv
// Decoupling FIFO between fetch and decode.
// Absorbs decode stalls; flush drops every held instruction.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = InstAddrBus,
  parameter int INST_W = InstBus
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_valid,
  input  logic [ADDR_W-1:0]      if_pc,
  input  logic [INST_W-1:0]      if_inst,
  output logic                   if_ready,
  input  logic                   flush,
  output logic                   id_valid,
  output logic [ADDR_W-1:0]      id_pc,
  output logic [INST_W-1:0]      id_inst,
  input  logic                   id_ready,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = ADDR_W + INST_W;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [EW-1:0] mem [DEPTH];

  assign if_ready = !full && (rst != RstEnable);
  assign id_valid = !empty;
  assign push     = if_valid && if_ready && !flush;
  assign pop      = id_valid && id_ready && !flush;

  fifo_ctrl #(
    .DEPTH(DEPTH)
  ) u_ctrl (
    .clk    (clk),
    .rst    (rst),
    .clr    (flush),
    .push   (push),
    .pop    (pop),
    .full   (full),
    .empty  (empty),
    .count  (count),
    .wr_addr(wr_addr),
    .rd_addr(rd_addr)
  );

  // Storage needs no reset: an empty buffer masks the head to zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_addr] <= {if_pc, if_inst};
  end

  always_comb begin
    id_pc   = '0;
    id_inst = '0;
    if (!empty) {id_pc, id_inst} = mem[rd_addr];
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Bench for inst_buffer: vector tables, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_inst_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid = 1'b0;
  logic [31:0] if_pc = '0;
  logic [31:0] if_inst = '0;
  logic        if_ready;
  logic        flush = 1'b0;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_ready = 1'b0;
  logic [2:0]  count;

  int total = 0;
  int bad = 0;

  inst_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .INST_W(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .if_valid(if_valid),
    .if_pc   (if_pc),
    .if_inst (if_inst),
    .if_ready(if_ready),
    .flush   (flush),
    .id_valid(id_valid),
    .id_pc   (id_pc),
    .id_inst (id_inst),
    .id_ready(id_ready),
    .count   (count)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t q[$];

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        rdy;
    logic        fl;
    logic        exp_ifr;
    logic        exp_vld;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic [2:0]  exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: check outputs against the model, clock, update model.
  task automatic cycle(input logic v, input logic [31:0] pc,
                       input logic [31:0] inst, input logic rdy,
                       input logic fl);
    bit          do_push;
    bit          do_pop;
    logic [31:0] hpc;
    logic [31:0] hinst;
    ent_t        e;
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst;
    id_ready = rdy;
    flush    = fl;
    #1;
    hpc   = (q.size() != 0) ? q[0].pc : 32'h0;
    hinst = (q.size() != 0) ? q[0].inst : 32'h0;
    chk("m_if_ready", if_ready, q.size() < DEPTH);
    chk("m_id_valid", id_valid, q.size() != 0);
    chk("m_id_pc", id_pc, hpc);
    chk("m_id_inst", id_inst, hinst);
    chk("m_count", count, q.size());
    do_push = v && (q.size() < DEPTH) && !fl;
    do_pop  = (q.size() != 0) && rdy && !fl;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e.pc   = pc;
        e.inst = inst;
        q.push_back(e);
      end
    end
    #1;
  endtask

  function automatic vec_t mk(logic v, logic [31:0] pc, logic [31:0] inst,
                              logic rdy, logic ifr, logic vld,
                              logic [31:0] epc, logic [31:0] einst,
                              logic [2:0] cnt);
    vec_t r;
    r.v = v; r.pc = pc; r.inst = inst; r.rdy = rdy; r.fl = 1'b0;
    r.exp_ifr = ifr; r.exp_vld = vld; r.exp_pc = epc;
    r.exp_inst = einst; r.exp_cnt = cnt;
    return r;
  endfunction

  task automatic run_vecs();
    for (int i = 0; i < vecs.size(); i++) begin
      if_valid = vecs[i].v;
      id_ready = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d_if_ready", i), if_ready, vecs[i].exp_ifr);
      cycle(vecs[i].v, vecs[i].pc, vecs[i].inst, vecs[i].rdy, vecs[i].fl);
      chk($sformatf("v%0d_id_valid", i), id_valid, vecs[i].exp_vld);
      chk($sformatf("v%0d_id_pc", i), id_pc, vecs[i].exp_pc);
      chk($sformatf("v%0d_id_inst", i), id_inst, vecs[i].exp_inst);
      chk($sformatf("v%0d_count", i), count, vecs[i].exp_cnt);
    end
    vecs.delete();
  endtask

  initial begin
    int pushes;
    #5;
    repeat (9) begin
      chk("rst_id_valid", id_valid, 0);
      chk("rst_id_pc", id_pc, 0);
      chk("rst_id_inst", id_inst, 0);
      chk("rst_count", count, 0);
      chk("rst_if_ready", if_ready, 0);
      #20;
    end
    #10;
    rst = 1'b0;
    #1;
    chk("rel_if_ready", if_ready, 1);
    chk("rel_id_valid", id_valid, 0);
    chk("rel_count", count, 0);
    @(posedge clk);
    #1;

    // Streaming with decode always ready
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 32'(4 * i), 32'h34011100 + 32'(i), 1,
                        1, 1, 32'(4 * i), 32'h34011100 + 32'(i), 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
    run_vecs();

    // Fill while stalled, then drain; fifth push waits for space
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 32'(4 * i), 32'h34011100 + 32'(i), 0,
                        1, 1, 32'h0, 32'h34011100, 3'(i + 1)));
    vecs.push_back(mk(1, 32'h10, 32'h34011104, 0,
                      0, 1, 32'h0, 32'h34011100, 4));
    vecs.push_back(mk(1, 32'h10, 32'h34011104, 1,
                      0, 1, 32'h4, 32'h34011101, 3));
    vecs.push_back(mk(1, 32'h10, 32'h34011104, 1,
                      1, 1, 32'h8, 32'h34011102, 3));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 32'hC, 32'h34011103, 2));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 32'h10, 32'h34011104, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 32'h0, 32'h0, 0));
    run_vecs();

    // Wrap-around with random decode stalls
    pushes = 0;
    while (pushes < 12) begin
      logic v;
      v = 1'($urandom_range(0, 1));
      if (v && q.size() < DEPTH) pushes++;
      cycle(v, $urandom, $urandom, 1'($urandom_range(0, 1)), 0);
    end

    // Flush colliding with push and pop at count = 3
    while (q.size() != 0) cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++)
      cycle(1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 0, 0);
    chk("pre_flush_count", count, 3);
    cycle(1, 32'hDEAD, 32'hBEEF, 1, 1);
    chk("flush_count", count, 0);
    chk("flush_id_valid", id_valid, 0);
    cycle(0, 0, 0, 1, 0);
    chk("flush_hold_valid", id_valid, 0);
    cycle(1, 32'h200, 32'h13, 1, 0);
    chk("post_flush_pc", id_pc, 32'h200);
    chk("post_flush_count", count, 1);
    cycle(0, 0, 0, 1, 0);

    // Async reset mid-stream with count = 2
    cycle(1, 32'h300, 32'h11, 0, 0);
    cycle(1, 32'h304, 32'h22, 0, 0);
    if_valid = 1'b0;
    chk("pre_rst_count", count, 2);
    #4;
    rst = 1'b1;
    #1;
    chk("arst_id_valid", id_valid, 0);
    chk("arst_count", count, 0);
    chk("arst_id_pc", id_pc, 0);
    chk("arst_if_ready", if_ready, 0);
    q.delete();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_rel_if_ready", if_ready, 1);
    @(posedge clk);
    #1;

    // Random traffic with occasional flush
    for (int i = 0; i < 80; i++)
      cycle(1'($urandom_range(0, 1)), $urandom, $urandom,
            1'($urandom_range(0, 2) != 0), $urandom_range(0, 9) == 0);
    while (q.size() != 0) cycle(0, 0, 0, 1, 0);
    chk("final_count", count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
